led_pwm_bank: RTL
=================

// Module: led_pwm_bank
// PURPOSE
//   N-channel PWM generator driving on-board LEDs (feeds RGB driver PWM inputs).
//   Per-channel duty registers are double-buffered: written any time, applied only
//   at a PWM period boundary, so outputs never glitch. Optional per-channel
//   "breathe" mode ramps duty 0->peak->0 once per period step.
// PARAMETERS
//   CHANNELS  3   number of PWM outputs (1..16)
//   PWM_BITS  8   duty/counter width; period = 2**PWM_BITS ticks
//   PRESCALE  48  clk cycles per PWM tick (>=1); 48 => 1 MHz tick at 48 MHz
//   OUT_INV   0   CHANNELS-bit mask; bit i set inverts pwm_out[i] (active-low LED)
// PORTS
//   clk           in   1                       system clock
//   rst           in   1                       async reset, active-high
//   duty_we       in   1                       write strobe for shadow duty
//   duty_sel      in   $clog2(CHANNELS) (>=1)  channel index for write
//   duty_wdata    in   PWM_BITS                duty (static) or peak (breathe)
//   mode          in   CHANNELS                bit i: 0 static, 1 breathe
//   pwm_out       out  CHANNELS                registered PWM outputs
//   period_start  out  1                       1-cycle pulse at each boundary
// BEHAVIOUR
//   Reset (async, rst=1): prescaler=0, cnt=0, shadow[i]=0, active[i]=0, ramp[i]=0,
//     dir[i]=up, period_start=0, pwm_out[i]=OUT_INV[i]. Release synchronous to clk.
//   Prescaler: counts 0..PRESCALE-1; tick asserted in cycle prescaler==PRESCALE-1,
//     then wraps to 0. PRESCALE=1 => tick every cycle.
//   Counter: cnt += 1 on tick, wraps 2**PWM_BITS-1 -> 0. Boundary = tick with
//     cnt==2**PWM_BITS-1. period_start registered: high the cycle after the
//     boundary edge (i.e. while cnt==0 first appears), exactly one clk wide.
//   Write: duty_we=1 and duty_sel<CHANNELS -> shadow[duty_sel]<=duty_wdata next edge.
//     duty_sel>=CHANNELS: write ignored, no state change.
//   Boundary update per channel (same edge as cnt wrap):
//     static : active<=shadow; ramp<=0; dir<=up.
//     breathe: up   & ramp<shadow  -> ramp<=ramp+1
//              up   & ramp>=shadow -> ramp<=shadow, dir<=down
//              down & ramp>0       -> ramp<=ramp-1
//              down & ramp==0      -> dir<=up (ramp stays 0)
//              active<=next ramp value.
//   Write coincident with boundary: active/ramp use shadow value BEFORE the write;
//     new value applies at the following boundary.
//   Mode change takes effect at next boundary only (mode sampled at boundary).
//   Output: pwm_out[i] <= (cnt < active[i]) ^ OUT_INV[i], registered every clk
//     => 1 clk latency from cnt. duty 0 -> never high; duty 2**PWM_BITS-1 -> high
//     2**PWM_BITS-1 of 2**PWM_BITS ticks (never 100%).
//   Widths: all compares unsigned PWM_BITS; ramp never exceeds 2**PWM_BITS-1,
//     never underflows below 0.
//   Reset mid-period: outputs return to OUT_INV immediately (async); cnt restarts
//     at 0; shadows cleared -- host must rewrite duties.
// TESTING (PRESCALE=1, PWM_BITS=4, CHANNELS=3, OUT_INV=0 unless stated)
//   1 Reset: rst=1 mid-run -> pwm_out=000, period_start=0 same cycle; after release
//     first period_start 16 cycles later, then every 16 cycles.
//   2 Static duty: write ch0=4, ch1=0, ch2=15 -> from next boundary, per 16-cycle
//     period ch0 high 4 cycles, ch1 never high, ch2 high 15 cycles.
//   3 Double buffer: write ch0=8 on boundary cycle, then ch0=2 mid-period -> next
//     period uses old duty, following period high exactly 2 cycles; no runt pulses.
//   4 Breathe: mode=001, ch0 peak=3 -> active per period 1,2,3,3,2,1,0,0,1... ;
//     lower peak to 1 while ramp=3 (down) -> ramp 2,1,0, then up only to 1.
//   5 Bad select: duty_we with duty_sel=3 -> no channel changes over 3 periods.
//   6 Prescale/invert: PRESCALE=48, OUT_INV=3'b010, ch1=0 -> pwm_out[1] constant 1;
//     period_start interval 768 clk cycles.

Source files
------------

// File: rtl/led_pwm_bank.sv
// N-channel LED PWM generator with double-buffered duty registers and an optional
// per-channel breathe mode that steps the duty once per PWM period.
module led_pwm_bank #(
    parameter int                 CHANNELS = 3,
    parameter int                 PWM_BITS = 8,
    parameter int                 PRESCALE = 48,
    parameter logic [CHANNELS-1:0] OUT_INV = '0,
    localparam int                SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                duty_we,
    input  logic [SEL_W-1:0]    duty_sel,
    input  logic [PWM_BITS-1:0] duty_wdata,
    input  logic [CHANNELS-1:0] mode,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);

    localparam int                PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]   PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
    localparam logic              DIR_UP   = 1'b0;
    localparam logic              DIR_DOWN = 1'b1;

    logic [PS_W-1:0]     presc_q, presc_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS-1:0] shadow_q [CHANNELS];
    logic [PWM_BITS-1:0] shadow_d [CHANNELS];
    logic [PWM_BITS-1:0] active_q [CHANNELS];
    logic [PWM_BITS-1:0] active_d [CHANNELS];
    logic [PWM_BITS-1:0] ramp_q   [CHANNELS];
    logic [PWM_BITS-1:0] ramp_d   [CHANNELS];
    logic [CHANNELS-1:0] dir_q, dir_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                ps_q, ps_d;
    logic                tick;
    logic                boundary;
    logic                wr_ok;

    // One breathe step; returns {dir_next, ramp_next}. Ramp is clamped to the peak
    // on the way up and held at zero on the way down, so it can never wrap.
    function automatic logic [PWM_BITS:0] breathe_step(
        input logic [PWM_BITS-1:0] ramp,
        input logic [PWM_BITS-1:0] peak,
        input logic                dir
    );
        logic [PWM_BITS:0] res;
        if (dir == DIR_UP) begin
            if (ramp < peak) res = {DIR_UP, ramp + 1'b1};
            else             res = {DIR_DOWN, peak};
        end else begin
            if (ramp != '0)  res = {DIR_DOWN, ramp - 1'b1};
            else             res = {DIR_UP, ramp};
        end
        return res;
    endfunction

    always_comb begin
        tick     = (presc_q == PS_LAST);
        presc_d  = tick ? '0 : presc_q + 1'b1;
        cnt_d    = tick ? cnt_q + 1'b1 : cnt_q;
        boundary = tick && (cnt_q == CNT_MAX);
        ps_d     = boundary;
        wr_ok    = duty_we && (32'(duty_sel) < CHANNELS);
        dir_d    = dir_q;
        pwm_d    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            shadow_d[i] = (wr_ok && (duty_sel == SEL_W'(i))) ? duty_wdata : shadow_q[i];
            active_d[i] = active_q[i];
            ramp_d[i]   = ramp_q[i];
            // Boundary reads shadow_q, so a coincident write lands one period later.
            if (boundary) begin
                if (mode[i]) begin
                    {dir_d[i], ramp_d[i]} = breathe_step(ramp_q[i], shadow_q[i], dir_q[i]);
                    active_d[i] = ramp_d[i];
                end else begin
                    active_d[i] = shadow_q[i];
                    ramp_d[i]   = '0;
                    dir_d[i]    = DIR_UP;
                end
            end
            pwm_d[i] = (cnt_q < active_q[i]) ^ OUT_INV[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q  <= '0;
            cnt_q    <= '0;
            shadow_q <= '{default: '0};
            active_q <= '{default: '0};
            ramp_q   <= '{default: '0};
            dir_q    <= {CHANNELS{DIR_UP}};
            pwm_q    <= OUT_INV;
            ps_q     <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            ramp_q   <= ramp_d;
            dir_q    <= dir_d;
            pwm_q    <= pwm_d;
            ps_q     <= ps_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;

endmodule
